// File: rtl/i2c_sensor_target.sv
// rtl/i2c_sensor_target.sv - clk-oversampled open-drain I2C target returning a clamped sensor byte
module i2c_sensor_target #(
    parameter logic [6:0] ADDRESS = 7'b0101010,
    parameter logic [7:0] P_MIN   = 8'd0,
    parameter logic [7:0] P_MAX   = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] sample_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, IGNORE
    } state_t;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, cnt_n;
    logic [7:0]  shreg, sh_n;
    logic        drive, drive_n;
    logic [7:0]  rxd_n;
    logic        rxv_n;

    logic scl_m, scl_s, scl_d;
    logic sda_m, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] clamped;

    // Synchronisers reset to the idle-bus level so release never fakes a START/STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {scl_m, scl_s, scl_d} <= 3'b111;
            {sda_m, sda_s, sda_d} <= 3'b111;
        end else begin
            scl_m <= scl_in;
            scl_s <= scl_m;
            scl_d <= scl_s;
            sda_m <= sda_in;
            sda_s <= sda_m;
            sda_d <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

    assign clamped = (sample_data < P_MIN) ? P_MIN :
                     (sample_data > P_MAX) ? P_MAX : sample_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'd0;
            drive    <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            shreg    <= sh_n;
            drive    <= drive_n;
            rx_data  <= rxd_n;
            rx_valid <= rxv_n;
        end
    end

    // In the ACK states, drive=0 means the ACK slot has not started yet;
    // the first scl fall asserts it and the second ends the slot.
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        drive_n = drive;
        rxd_n   = rx_data;
        rxv_n   = 1'b0;
        if (stop_det) begin
            state_n = IDLE;
            drive_n = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            drive_n = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sh_n  = {shreg[6:0], sda_s};
                        cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7)
                            state_n = (shreg[6:0] == ADDRESS) ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!drive) begin
                            drive_n = 1'b1;
                        end else begin
                            drive_n = 1'b0;
                            cnt_n   = 4'd0;
                            if (shreg[0]) begin
                                sh_n    = clamped;
                                state_n = TX_BYTE;
                            end else begin
                                state_n = RX_BYTE;
                            end
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8)
                            state_n = TX_ACK;
                        else
                            sh_n = {shreg[6:0], 1'b0};
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_n = IGNORE;
                    end else if (scl_fall) begin
                        sh_n    = clamped;
                        cnt_n   = 4'd0;
                        state_n = TX_BYTE;
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        sh_n  = {shreg[6:0], sda_s};
                        cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rxd_n   = {shreg[6:0], sda_s};
                            rxv_n   = 1'b1;
                            state_n = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!drive) begin
                            drive_n = 1'b1;
                        end else begin
                            drive_n = 1'b0;
                            cnt_n   = 4'd0;
                            state_n = RX_BYTE;
                        end
                    end
                end
                default: drive_n = 1'b0;
            endcase
        end
    end

    // TX data comes straight from the shift MSB, which only moves on scl falls.
    always_comb begin
        sda_oe = 1'b0;
        busy   = 1'b0;
        case (state)
            ADDR_ACK: begin sda_oe = drive;     busy = 1'b1; end
            TX_BYTE:  begin sda_oe = ~shreg[7]; busy = 1'b1; end
            TX_ACK:   busy = 1'b1;
            RX_BYTE:  busy = 1'b1;
            RX_ACK:   begin sda_oe = drive;     busy = 1'b1; end
            default:  sda_oe = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_i2c_sensor_target.sv
// tb/tb_i2c_sensor_target.sv - bit-banged I2C controller bench with vector table and random transactions
module tb_i2c_sensor_target;

    localparam int Q = 4;
    localparam logic [6:0] ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_c = 1'b1;
    logic       sda_c = 1'b1;
    logic       sda_bus;
    logic       sda_oe, rx_valid, busy;
    logic [7:0] sample_data = 8'd0;
    logic [7:0] rx_data;

    always #5 clk = ~clk;
    assign sda_bus = sda_c & ~sda_oe;

    i2c_sensor_target #(.ADDRESS(ADDR), .P_MIN(8'd10), .P_MAX(8'd100)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_c), .sda_in(sda_bus), .sda_oe(sda_oe),
        .sample_data(sample_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    int ncmp = 0;
    int nfail = 0;
    logic [7:0] rx_q[$];
    bit busy_seen, oe_seen;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (busy) busy_seen = 1'b1;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_clamp(input logic [7:0] s);
        int v;
        v = s;
        if (v < 10) v = 10;
        if (v > 100) v = 100;
        return v[7:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_c = b;  tick(Q);
        scl_c = 1'b1; tick(Q);
        r = sda_bus; tick(Q);
        scl_c = 1'b0; tick(Q);
    endtask

    task automatic i2c_start;
        sda_c = 1'b1; tick(Q);
        scl_c = 1'b1; tick(Q);
        sda_c = 1'b0; tick(Q);
        scl_c = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_c = 1'b0; tick(Q);
        scl_c = 1'b1; tick(Q);
        sda_c = 1'b1; tick(Q);
    endtask

    task automatic send8(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    endtask

    // Returns 1 when the target pulled SDA low in the ninth slot.
    task automatic get_ack(output logic ack);
        logic r;
        bit_xfer(1'b1, r);
        ack = !r;
    endtask

    // Reads a byte; scrambles sample_data mid-byte, then presents the next sample before the ACK slot.
    task automatic recv_byte(input logic [7:0] next_sample, input logic ack_out, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            b[i] = r;
            if (i == 6) sample_data = 8'($urandom);
        end
        sample_data = next_sample;
        bit_xfer(!ack_out, r);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        ncmp++; nfail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] vals[3];
        logic [6:0] a;
        logic       rw;
        int         n;

        vecs[0] = '{ADDR,  1'b1, 8'd55,  1'b1, 8'h37};
        vecs[1] = '{ADDR,  1'b1, 8'd150, 1'b1, 8'h64};
        vecs[2] = '{ADDR,  1'b1, 8'd0,   1'b1, 8'h0A};
        vecs[3] = '{ADDR,  1'b1, 8'd10,  1'b1, 8'h0A};
        vecs[4] = '{ADDR,  1'b1, 8'd101, 1'b1, 8'h64};
        vecs[5] = '{ADDR,  1'b1, 8'd9,   1'b1, 8'h0A};
        vecs[6] = '{ADDR,  1'b0, 8'hA5,  1'b1, 8'hA5};
        vecs[7] = '{ADDR,  1'b0, 8'h3C,  1'b1, 8'h3C};
        vecs[8] = '{7'h2B, 1'b1, 8'd55,  1'b0, 8'h00};
        vecs[9] = '{7'h2B, 1'b0, 8'h5A,  1'b0, 8'h00};

        tick(3);
        check("reset sda_oe", sda_oe, 0);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset busy", busy, 0);
        rst = 1'b1;
        tick(4);

        foreach (vecs[k]) begin
            rx_q.delete(); busy_seen = 0; oe_seen = 0;
            i2c_start;
            send8({vecs[k].addr, vecs[k].rw});
            if (vecs[k].rw) sample_data = vecs[k].data;
            get_ack(ack);
            check($sformatf("vec%0d addr ack", k), ack, vecs[k].exp_ack);
            if (ack) begin
                if (vecs[k].rw) begin
                    recv_byte(8'd0, 1'b0, b);
                    check($sformatf("vec%0d read byte", k), b, vecs[k].exp_byte);
                end else begin
                    send8(vecs[k].data);
                    get_ack(ack);
                    check($sformatf("vec%0d data ack", k), ack, 1);
                end
            end
            i2c_stop;
            check($sformatf("vec%0d busy after stop", k), busy, 0);
            if (!vecs[k].exp_ack) begin
                check($sformatf("vec%0d busy never", k), busy_seen, 0);
                check($sformatf("vec%0d sda never driven", k), oe_seen, 0);
            end
            if (!vecs[k].rw) begin
                check($sformatf("vec%0d rx count", k), rx_q.size(), vecs[k].exp_ack ? 1 : 0);
                if (rx_q.size() > 0) check($sformatf("vec%0d rx_data", k), rx_q[0], vecs[k].exp_byte);
            end
        end

        // Two-byte read with clamping on both ends.
        i2c_start; send8({ADDR, 1'b1}); sample_data = 8'd150; get_ack(ack);
        check("mread ack", ack, 1);
        recv_byte(8'd0, 1'b1, b);   check("mread byte0", b, 8'h64);
        recv_byte(8'd0, 1'b0, b);   check("mread byte1", b, 8'h0A);
        i2c_stop;

        // Two-byte write.
        rx_q.delete();
        i2c_start; send8({ADDR, 1'b0}); get_ack(ack); check("mwrite addr ack", ack, 1);
        send8(8'hA5); get_ack(ack); check("mwrite ack0", ack, 1);
        send8(8'h3C); get_ack(ack); check("mwrite ack1", ack, 1);
        i2c_stop;
        check("mwrite rx count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("mwrite rx0", rx_q[0], 8'hA5);
            check("mwrite rx1", rx_q[1], 8'h3C);
        end

        // Repeated START after four data bits of a read.
        i2c_start; send8({ADDR, 1'b1}); sample_data = 8'h0F; get_ack(ack);
        check("rstart ack", ack, 1);
        recv_nibble: for (int i = 0; i < 4; i++) begin
            logic r;
            bit_xfer(1'b1, r);
            check("rstart hi bit", r, 0);
        end
        sda_c = 1'b1; tick(Q);
        scl_c = 1'b1; tick(Q);
        sda_c = 1'b0; tick(3);
        check("rstart oe released", sda_oe, 0);
        tick(1);
        scl_c = 1'b0; tick(Q);
        send8({ADDR, 1'b1}); sample_data = 8'd55; get_ack(ack);
        check("rstart readdr ack", ack, 1);
        recv_byte(8'd0, 1'b0, b); check("rstart byte", b, 8'h37);
        i2c_stop;

        // Reset asserted while the target drives the address ACK.
        i2c_start; send8({ADDR, 1'b1}); sample_data = 8'd55;
        sda_c = 1'b1; tick(Q); scl_c = 1'b1; tick(2);
        check("rst pre oe", sda_oe, 1);
        rst = 1'b0; #1;
        check("rst async oe", sda_oe, 0);
        tick(3); rst = 1'b1; tick(2);
        scl_c = 1'b0; tick(Q);
        oe_seen = 0; busy_seen = 0;
        send8(8'h00); get_ack(ack);
        check("post-rst no ack", ack, 0);
        check("post-rst oe idle", oe_seen, 0);
        check("post-rst busy idle", busy_seen, 0);
        i2c_stop;
        i2c_start; send8({ADDR, 1'b1}); sample_data = 8'd55; get_ack(ack);
        check("post-rst fresh ack", ack, 1);
        recv_byte(8'd0, 1'b0, b); check("post-rst byte", b, 8'h37);
        i2c_stop;

        // Random transactions against the clamp / address-match model.
        for (int t = 0; t < 30; t++) begin
            a = ($urandom_range(0, 3) != 0) ? ADDR : 7'($urandom);
            if (a == ADDR && $urandom_range(0, 3) == 0) a = ADDR ^ 7'h01;
            rw = 1'($urandom);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 2))
                    0:       vals[i] = 8'($urandom_range(0, 14));
                    1:       vals[i] = 8'($urandom_range(95, 110));
                    default: vals[i] = 8'($urandom);
                endcase
            end
            rx_q.delete(); busy_seen = 0;
            i2c_start; send8({a, rw});
            sample_data = vals[0];
            get_ack(ack);
            check($sformatf("rnd%0d ack", t), ack, (a == ADDR) ? 1 : 0);
            if (ack) begin
                for (int i = 0; i < n; i++) begin
                    if (rw) begin
                        recv_byte((i < n - 1) ? vals[i + 1] : 8'd0, (i < n - 1) ? 1'b1 : 1'b0, b);
                        check($sformatf("rnd%0d rbyte%0d", t, i), b, ref_clamp(vals[i]));
                    end else begin
                        send8(vals[i]); get_ack(ack);
                        check($sformatf("rnd%0d wack%0d", t, i), ack, 1);
                    end
                end
            end
            i2c_stop;
            check($sformatf("rnd%0d busy after stop", t), busy, 0);
            if (a != ADDR) check($sformatf("rnd%0d busy never", t), busy_seen, 0);
            check($sformatf("rnd%0d rx count", t), rx_q.size(), (!rw && a == ADDR) ? n : 0);
            for (int i = 0; i < n; i++)
                if (i < rx_q.size()) check($sformatf("rnd%0d rx%0d", t, i), rx_q[i], vals[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
